dm_access_ctrl: RTL
===================

Name: dm_access_ctrl

Overview:
- Memory-stage controller directly upstream of the word-addressed data memory (DM).
- Converts pipeline load/store requests (byte/half/word, signed/unsigned) into DM word accesses.
- Sub-word stores use a 2-cycle read-modify-write with a pipeline stall.
- Load data is extracted and extended from the DM read word.

Parameters:
- DM_WORDS, 3072, number of valid DM words; word index >= DM_WORDS is out of range.
- ADDR_HI, 13, top DM address bit; DM word index = addr[ADDR_HI:2].

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- req_valid  input  1  memory-stage request present.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 half, 10 word, 11 reserved (treated as word).
- req_sign  input  1  loads: 1 = sign-extend, 0 = zero-extend.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned.
- req_pc  input  32  PC of the requesting instruction.
- dm_rdata  input  32  DM combinational read word.
- dm_addr  output  12  DM word address, [13:2].
- dm_we  output  1  DM write enable.
- dm_wdata  output  32  DM write word.
- dm_pc  output  32  PC forwarded to DM for write trace.
- rdata  output  32  extended load result (combinational).
- stall  output  1  hold pipeline (request inputs stable next cycle).
- addr_exc  output  1  misaligned or out-of-range access.

Behaviour:
- State machine: IDLE, MERGE. Reset → IDLE.
- Registers: sv_addr, sv_data, sv_size, sv_pc. All reset to 0.
- Outputs in reset: dm_we = 0, stall = 0, addr_exc = 0.
- Bad access (addr_exc = 1, combinational, IDLE only):
  - half with addr[0] = 1;
  - word with addr[1:0] != 0;
  - addr[31:ADDR_HI+1] != 0;
  - word index >= DM_WORDS.
- On a bad access: no DM write, no state change, stall = 0, rdata = 0.
- IDLE, no request or valid load:
  - dm_addr = req_addr[13:2], dm_we = 0, stall = 0.
  - Loads have 0-cycle latency:
    - byte = dm_rdata lane addr[1:0] (lane 0 = bits 7:0);
    - half = lane addr[1] (lane 0 = bits 15:0);
    - extended per req_sign.
- IDLE, valid word store: dm_we = 1, dm_wdata = req_wdata, dm_pc = req_pc, stall = 0; stays IDLE. DM writes at the same edge.
- IDLE, valid byte/half store: dm_we = 0, dm_addr = req addr, stall = 1. At the edge: latch sv_*, go to MERGE.
- MERGE:
  - dm_addr = sv_addr[13:2], dm_we = 1, dm_pc = sv_pc, stall = 0.
  - dm_wdata = dm_rdata with the addressed byte/half lane replaced by sv_data[7:0] or [15:0]; other lanes unchanged.
  - Request inputs are ignored (same instruction still held).
  - Go to IDLE at the edge.
- Back-to-back sub-word stores: each costs 2 cycles; the second sees the first's merged word.
- Load immediately after a store reads the updated word (DM writes at the edge).
- Reset asserted in MERGE: return to IDLE immediately, dm_we drops to 0, no write occurs.
- addr_exc is never asserted in MERGE.

Optional Feature:
- Macro: DM_MISALIGN_EXC_EN.
- Defined: misaligned half/word accesses raise addr_exc as above.
- Undefined:
  - misalignment is not an error; address is aligned down (half: addr[0] ignored, word: addr[1:0] ignored);
  - the access proceeds normally;
  - addr_exc reports only out-of-range conditions.

Test Plan:
- Word store addr 0x10, data 0xDEADBEEF, pc 0x3000 → dm_we = 1 same cycle, dm_addr = 0x004, stall = 0; then word load 0x10 → rdata = 0xDEADBEEF.
- DM[4] = 0x11223344; sb addr 0x12, data 0xAA → cycle 0 stall = 1, dm_we = 0; cycle 1 dm_we = 1, dm_wdata = 0x11AA3344; IDLE after.
- DM[4] = 0x11AA3344; lb addr 0x12 signed → 0xFFFFFFAA; lbu → 0x000000AA; lh addr 0x12 signed → 0x000011AA.
- sh addr 0x11 with DM_MISALIGN_EXC_EN → addr_exc = 1, no write, stall = 0; without the macro → half lane 0 written, addr_exc = 0.
- Word store addr 0x3000 (index 3072) → addr_exc = 1, dm_we = 0 throughout.
- sb issued, reset driven low during MERGE → state IDLE, dm_we = 0, DM word unchanged after reset release.

Source files
------------

// File: rtl/dm_access_ctrl.sv
// dm_access_ctrl: turns byte/half/word load-store requests into word accesses on the DM.
// Sub-word stores use an IDLE->MERGE read-modify-write. Define DM_MISALIGN_EXC_EN to trap misaligned half/word.
module dm_access_ctrl #(
    parameter int DM_WORDS = 3072,
    parameter int ADDR_HI  = 13
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    input  logic               req_we,
    input  logic [1:0]         req_size,
    input  logic               req_sign,
    input  logic [31:0]        req_addr,
    input  logic [31:0]        req_wdata,
    input  logic [31:0]        req_pc,
    input  logic [31:0]        dm_rdata,
    output logic [ADDR_HI-2:0] dm_addr,
    output logic               dm_we,
    output logic [31:0]        dm_wdata,
    output logic [31:0]        dm_pc,
    output logic [31:0]        rdata,
    output logic               stall,
    output logic               addr_exc
);
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;

    typedef enum logic {IDLE, MERGE} state_t;

    state_t             state_q, state_d;
    logic [ADDR_HI:0]   sv_addr_q, sv_addr_d;
    logic [15:0]        sv_data_q, sv_data_d;
    logic [1:0]         sv_size_q, sv_size_d;
    logic [31:0]        sv_pc_q, sv_pc_d;

    logic [31:0] word_idx;
    logic        out_of_range;
    logic        bad;
    logic        sub_word;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] merged;

    assign word_idx     = {{(33-ADDR_HI){1'b0}}, req_addr[ADDR_HI:2]};
    assign out_of_range = (req_addr[31:ADDR_HI+1] != '0) || (word_idx >= DM_WORDS);
    assign sub_word     = ~req_size[1];

`ifdef DM_MISALIGN_EXC_EN
    logic misalign;
    assign misalign = (req_size == SZ_HALF) ? req_addr[0] :
                      (req_size[1] ? (req_addr[1:0] != 2'b00) : 1'b0);
    assign bad      = out_of_range | misalign;
`else
    // Misaligned half/word simply align down: lane selection never looks at the low bits.
    assign bad      = out_of_range;
`endif

    always_comb begin
        byte_lane = dm_rdata[7:0];
        case (req_addr[1:0])
            2'd1:    byte_lane = dm_rdata[15:8];
            2'd2:    byte_lane = dm_rdata[23:16];
            2'd3:    byte_lane = dm_rdata[31:24];
            default: byte_lane = dm_rdata[7:0];
        endcase
        half_lane = req_addr[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    end

    always_comb begin
        case (req_size)
            SZ_BYTE: rdata = req_sign ? {{24{byte_lane[7]}}, byte_lane} : {24'b0, byte_lane};
            SZ_HALF: rdata = req_sign ? {{16{half_lane[15]}}, half_lane} : {16'b0, half_lane};
            default: rdata = dm_rdata;
        endcase
        if (addr_exc) rdata = '0;
    end

    always_comb begin
        merged = dm_rdata;
        if (sv_size_q == SZ_BYTE) begin
            case (sv_addr_q[1:0])
                2'd1:    merged[15:8]  = sv_data_q[7:0];
                2'd2:    merged[23:16] = sv_data_q[7:0];
                2'd3:    merged[31:24] = sv_data_q[7:0];
                default: merged[7:0]   = sv_data_q[7:0];
            endcase
        end else if (sv_addr_q[1]) begin
            merged[31:16] = sv_data_q;
        end else begin
            merged[15:0] = sv_data_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            sv_addr_q <= '0;
            sv_data_q <= '0;
            sv_size_q <= '0;
            sv_pc_q   <= '0;
        end else begin
            state_q   <= state_d;
            sv_addr_q <= sv_addr_d;
            sv_data_q <= sv_data_d;
            sv_size_q <= sv_size_d;
            sv_pc_q   <= sv_pc_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sv_addr_d = sv_addr_q;
        sv_data_d = sv_data_q;
        sv_size_d = sv_size_q;
        sv_pc_d   = sv_pc_q;
        dm_addr   = req_addr[ADDR_HI:2];
        dm_we     = 1'b0;
        dm_wdata  = req_wdata;
        dm_pc     = req_pc;
        stall     = 1'b0;
        addr_exc  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (bad) begin
                        addr_exc = 1'b1;
                    end else if (req_we && sub_word) begin
                        stall     = 1'b1;
                        state_d   = MERGE;
                        sv_addr_d = req_addr[ADDR_HI:0];
                        sv_data_d = req_wdata[15:0];
                        sv_size_d = req_size;
                        sv_pc_d   = req_pc;
                    end else if (req_we) begin
                        dm_we = 1'b1;
                    end
                end
            end
            MERGE: begin
                dm_addr  = sv_addr_q[ADDR_HI:2];
                dm_we    = 1'b1;
                dm_wdata = merged;
                dm_pc    = sv_pc_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Reset asserted mid-MERGE must not leak a write while the state register clears.
        if (!reset) begin
            dm_we    = 1'b0;
            stall    = 1'b0;
            addr_exc = 1'b0;
        end
    end
endmodule
